cdc_2phase_src_clearable: RTL

CDC_2PHASE_SRC_CLEARABLE -- requirements
Module: cdc_2phase_src_clearable

---
 rtl/cdc_2phase_src_clearable.sv | 55 +++++
 1 files changed

// File: rtl/cdc_2phase_src_clearable.sv
// Source half of a 2-phase (toggle) request/acknowledge CDC channel.
// Holds one payload at a time; a synchronous clear abandons the transfer in flight.
module cdc_2phase_src_clearable #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_WIDTH  = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  async_req_o,
  input  logic                  async_ack_i,
  output logic [DATA_WIDTH-1:0] async_data_o
);

  (* async_reg = "true", dont_touch = "true" *)
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_synced;
  logic                   req_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  assign ack_synced = ack_sync_q[SYNC_STAGES-1];

  // Idle when the synchronised ack has caught up with the request toggle;
  // clear masks ready so a simultaneous valid can never be accepted.
  assign ready_o = (req_q == ack_synced) && !clear_i;
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else if (clear_i) begin
      req_q  <= 1'b0;
    end else if (accept) begin
      req_q  <= ~req_q;
      data_q <= data_i;
    end
  end

  assign async_req_o  = req_q;
  assign async_data_o = data_q;

endmodule
